// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: video read port, CPU read/write port,
// shared RAM port and debug grant. slave = arbiter view, master = environment view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  vid_valid_i;
  logic [ADDR_WIDTH-1:0] vid_addr_i;
  logic                  vid_ready_o;

  logic                  cpu_valid_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i;
  logic [STRB_WIDTH-1:0] cpu_wstrb_i;
  logic                  cpu_ready_o;

  logic [DATA_WIDTH-1:0] rdata_o;

  logic                  mem_valid_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [STRB_WIDTH-1:0] mem_wstrb_o;
  logic                  mem_ready_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic [1:0]            grant_o;

  modport slave (
    input  vid_valid_i, vid_addr_i,
    input  cpu_valid_i, cpu_addr_i, cpu_wdata_i, cpu_wstrb_i,
    input  mem_ready_i, mem_rdata_i,
    output vid_ready_o, cpu_ready_o, rdata_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output grant_o
  );

  modport master (
    output vid_valid_i, vid_addr_i,
    output cpu_valid_i, cpu_addr_i, cpu_wdata_i, cpu_wstrb_i,
    output mem_ready_i, mem_rdata_i,
    input  vid_ready_o, cpu_ready_o, rdata_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  grant_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between video scan-out (priority, read-only) and the CPU,
// with a saturating loss counter that forces a CPU grant after STARVE_LIMIT losses.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic         clk,
  input  logic         reset_i,
  mem_arbiter_if.slave bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0]  LIMIT      = 8'(STARVE_LIMIT);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                r_state;
  logic                  r_owner;
  logic [7:0]            r_lose_cnt;

  logic                  w_busy;
  logic                  w_vid_own;
  logic                  w_cpu_own;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_WIDTH-1:0] w_wstrb;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_lose_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // CPU wins when alone, or when contending after enough losses
          if (bus.cpu_valid_i && (!bus.vid_valid_i || (r_lose_cnt >= LIMIT))) begin
            r_state    <= S_BUSY;
            r_owner    <= 1'b1;
            r_lose_cnt <= '0;
          end else if (bus.vid_valid_i) begin
            r_state <= S_BUSY;
            r_owner <= 1'b0;
            if (bus.cpu_valid_i && (r_lose_cnt < LIMIT))
              r_lose_cnt <= r_lose_cnt + 8'd1;
          end
        end
        S_BUSY: begin
          if (bus.mem_ready_i)
            r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_busy    = (r_state == S_BUSY);
  assign w_cpu_own = w_busy && r_owner;
  assign w_vid_own = w_busy && !r_owner;

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_wstrb = '0;
    if (w_cpu_own) begin
      w_addr  = bus.cpu_addr_i;
      w_wdata = bus.cpu_wdata_i;
      w_wstrb = bus.cpu_wstrb_i;
    end else if (w_vid_own) begin
      w_addr  = bus.vid_addr_i;
    end
  end

  assign bus.mem_valid_o = w_busy;
  assign bus.mem_addr_o  = w_addr;
  assign bus.mem_wdata_o = w_wdata;
  assign bus.mem_wstrb_o = w_wstrb;

  assign bus.vid_ready_o = w_vid_own && bus.mem_ready_i;
  assign bus.cpu_ready_o = w_cpu_own && bus.mem_ready_i;
  assign bus.rdata_o     = bus.mem_rdata_i;
  assign bus.grant_o     = {w_cpu_own, w_vid_own};
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// with a RAM model, per-requester scoreboards and a transaction-level arbitration model.
module tb_mem_arbiter;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 2;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] vid_data(input logic [31:0] a);
    if (a == 32'h1000) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // RAM contents and the bench's own view of what the CPU region should hold
  logic [31:0] ram    [16];
  logic [31:0] shadow [16];

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } cpu_exp_t;

  logic [31:0] vid_q [$];
  cpu_exp_t    cpu_q [$];
  bit          act_grants [$];

  // RAM model controls
  int fixed_wait = 0;
  int cur_wait   = 0;
  int wcnt       = 0;
  bit ram_hold   = 0;
  bit spurious   = 0;
  bit ram_glitch = 0;

  task automatic set_wait(input int w);
    fixed_wait = w;
    cur_wait   = (w >= 0) ? w : int'($urandom_range(0, 3));
  endtask

  task automatic ram_access();
    logic [31:0] a;
    logic [3:0]  idx;
    a = bus.mem_addr_o;
    if (a >= 32'h1000) begin
      bus.mem_rdata_i = vid_data(a);
    end else begin
      idx = a[5:2];
      bus.mem_rdata_i = ram[idx];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb_o[b]) ram[idx][8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
    end
  endtask

  initial begin
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_i) begin
        bus.mem_ready_i = ram_glitch;
        wcnt = 0;
      end else if (spurious) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = $urandom;
      end else if (bus.mem_ready_i) begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = $urandom;
        wcnt = 0;
        cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end else if (bus.mem_valid_o && !ram_hold) begin
        if (wcnt == cur_wait) begin
          bus.mem_ready_i = 1'b1;
          ram_access();
        end else begin
          wcnt++;
          bus.mem_rdata_i = $urandom;
        end
      end else begin
        bus.mem_rdata_i = $urandom;
      end
    end
  end

  // Transaction-level arbitration model and output monitor
  bit          m_busy = 0;
  bit          m_owner = 0;
  int          m_lose = 0;
  int          busy_len = 0;
  bit          pvv = 0, pcv = 0, pmr = 0;
  logic [1:0]  exp_g;
  logic [31:0] exp_addr;
  cpu_exp_t    ce;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        m_busy = 0; m_owner = 0; m_lose = 0; busy_len = 0;
        pvv = 0; pcv = 0; pmr = 0;
        continue;
      end
      if (!m_busy) begin
        if (pvv || pcv) begin
          m_busy   = 1;
          busy_len = 0;
          m_owner  = (pvv && pcv) ? (m_lose >= int'(LIMIT)) : pcv;
          if (m_owner) m_lose = 0;
          else if (pcv && m_lose < int'(LIMIT)) m_lose++;
          act_grants.push_back(bus.grant_o[1]);
        end
      end else if (pmr) begin
        m_busy = 0;
      end

      exp_g    = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      exp_addr = !m_busy ? 32'h0 : (m_owner ? bus.cpu_addr_i : bus.vid_addr_i);
      check("grant_o", bus.grant_o, exp_g);
      check("mem_valid_o", bus.mem_valid_o, m_busy);
      check("mem_addr_o", bus.mem_addr_o, exp_addr);
      check("mem_wdata_o", bus.mem_wdata_o, (m_busy && m_owner) ? bus.cpu_wdata_i : 32'h0);
      check("mem_wstrb_o", bus.mem_wstrb_o, (m_busy && m_owner) ? bus.cpu_wstrb_i : 4'h0);
      check("vid_ready_o", bus.vid_ready_o, m_busy && !m_owner && bus.mem_ready_i);
      check("cpu_ready_o", bus.cpu_ready_o, m_busy && m_owner && bus.mem_ready_i);
      check("rdata_o", bus.rdata_o, bus.mem_rdata_i);
      if (m_busy) begin
        busy_len++;
        if (bus.mem_ready_i) check("busy_cycles", busy_len, cur_wait + 1);
      end

      if (bus.vid_ready_o) begin
        check("vid_pending", vid_q.size() > 0, 1'b1);
        if (vid_q.size() > 0) check("vid_rdata", bus.rdata_o, vid_q.pop_front());
      end
      if (bus.cpu_ready_o) begin
        check("cpu_pending", cpu_q.size() > 0, 1'b1);
        if (cpu_q.size() > 0) begin
          ce = cpu_q.pop_front();
          if (ce.is_read) check("cpu_rdata", bus.rdata_o, ce.data);
        end
      end

      pvv = bus.vid_valid_i;
      pcv = bus.cpu_valid_i;
      pmr = bus.mem_ready_i;
    end
  end

  // Requester drivers: called at posedge+1, return at posedge+1
  task automatic vid_txn(input logic [31:0] addr, input int gap);
    int t;
    bus.vid_addr_i  = addr;
    bus.vid_valid_i = 1'b1;
    vid_q.push_back(vid_data(addr));
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.vid_ready_o && t < 400);
    check("vid_ready_timeout", bus.vid_ready_o, 1'b1);
    if (!bus.vid_ready_o && vid_q.size() > 0) void'(vid_q.pop_back());
    @(posedge clk); #1;
    if (gap > 0) begin
      bus.vid_valid_i = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int gap);
    int       t;
    logic [3:0] idx;
    cpu_exp_t e;
    idx = addr[5:2];
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    bus.cpu_wstrb_i = wstrb;
    bus.cpu_valid_i = 1'b1;
    if (wstrb == 4'h0) begin
      e.is_read = 1'b1;
      e.data    = shadow[idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
      e.is_read = 1'b0;
      e.data    = 32'h0;
    end
    cpu_q.push_back(e);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.cpu_ready_o && t < 400);
    check("cpu_ready_timeout", bus.cpu_ready_o, 1'b1);
    if (!bus.cpu_ready_o && cpu_q.size() > 0) void'(cpu_q.pop_back());
    @(posedge clk); #1;
    if (gap > 0) begin
      bus.cpu_valid_i = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] w;
    reset_i         = 1'b0;
    bus.vid_valid_i = 1'b0;
    bus.vid_addr_i  = '0;
    bus.cpu_valid_i = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    bus.cpu_wstrb_i = '0;
    for (int i = 0; i < 16; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end

    repeat (3) @(negedge clk);
    check("rst_mem_valid", bus.mem_valid_o, 1'b0);
    check("rst_vid_ready", bus.vid_ready_o, 1'b0);
    check("rst_cpu_ready", bus.cpu_ready_o, 1'b0);
    check("rst_grant", bus.grant_o, 2'b00);
    check("rst_addr", bus.mem_addr_o, 32'h0);
    check("rst_wdata", bus.mem_wdata_o, 32'h0);
    check("rst_wstrb", bus.mem_wstrb_o, 4'h0);
    #2 reset_i = 1'b1;
    @(posedge clk); #1;

    // CPU write alone, zero-wait, then read back
    set_wait(0);
    act_grants.delete();
    cpu_txn(32'h100, 32'hDEAD_BEEF, 4'hF, 1);
    cpu_txn(32'h100, 32'h0, 4'h0, 1);
    check("cpu_alone_ngrants", act_grants.size(), 2);
    if (act_grants.size() == 2) check("cpu_alone_owner", act_grants[0], 1'b1);

    // Video read with three wait states
    set_wait(3);
    act_grants.delete();
    vid_txn(32'h1000, 1);
    check("vid_wait_ngrants", act_grants.size(), 1);
    if (act_grants.size() == 1) check("vid_wait_owner", act_grants[0], 1'b0);

    // Simultaneous first requests: video first, then CPU
    set_wait(0);
    act_grants.delete();
    fork
      vid_txn(32'h1004, 1);
      cpu_txn(32'h104, 32'h0BAD_F00D, 4'h3, 1);
    join
    check("simul_ngrants", act_grants.size(), 2);
    if (act_grants.size() == 2) begin
      check("simul_first", act_grants[0], 1'b0);
      check("simul_second", act_grants[1], 1'b1);
    end

    // Starvation with both requesters continuously valid
    set_wait(-1);
    act_grants.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) vid_txn(32'h1010 + 32'(4 * i), 0);
        bus.vid_valid_i = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) cpu_txn(32'h110 + 32'(4 * i), 32'h0, 4'h0, 0);
        bus.cpu_valid_i = 1'b0;
      end
    join
    check("starve_ngrants", act_grants.size(), 9);
    if (act_grants.size() == 9)
      for (int k = 0; k < 9; k++) check($sformatf("starve_order%0d", k), act_grants[k], (k % 3) == 2);

    // Spurious RAM ready while idle
    repeat (2) @(posedge clk);
    act_grants.delete();
    spurious = 1'b1;
    repeat (4) @(posedge clk);
    spurious = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("spurious_ngrants", act_grants.size(), 0);

    // Reset in the middle of a held CPU write
    ram_hold        = 1'b1;
    bus.cpu_addr_i  = 32'h108;
    bus.cpu_wdata_i = 32'hCAFE_F00D;
    bus.cpu_wstrb_i = 4'hF;
    bus.cpu_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("midrst_busy_before", bus.mem_valid_o, 1'b1);
    ram_glitch      = 1'b1;
    reset_i         = 1'b0;
    bus.cpu_valid_i = 1'b0;
    #1;
    check("midrst_mem_valid", bus.mem_valid_o, 1'b0);
    check("midrst_grant", bus.grant_o, 2'b00);
    check("midrst_cpu_ready", bus.cpu_ready_o, 1'b0);
    @(posedge clk); #2;
    check("midrst_mready_seen", bus.mem_ready_i, 1'b1);
    check("midrst_cpu_ready2", bus.cpu_ready_o, 1'b0);
    check("midrst_vid_ready2", bus.vid_ready_o, 1'b0);
    @(negedge clk); #2;
    ram_glitch = 1'b0;
    ram_hold   = 1'b0;
    reset_i    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cpu_txn(32'h108, 32'h1357_9BDF, 4'hF, 1);
    cpu_txn(32'h108, 32'h0, 4'h0, 1);

    // Randomized concurrent traffic
    set_wait(-1);
    fork
      begin
        for (int i = 0; i < 60; i++)
          vid_txn(32'h1000 + ($urandom_range(0, 63) << 2), int'($urandom_range(0, 3)));
        bus.vid_valid_i = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          cpu_txn(32'h100 + ($urandom_range(0, 15) << 2), $urandom, w, int'($urandom_range(0, 3)));
        end
        bus.cpu_valid_i = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("vid_q_drained", vid_q.size(), 0);
    check("cpu_q_drained", cpu_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
